adc_capture_avg: RTL and testbench

ADC_CAPTURE_AVG -- requirements
Module: adc_capture_avg

---
 rtl/adc_capture_avg.sv | 110 +++++++++++
 tb/tb_adc_capture_avg.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_avg.sv
// ADC capture on OE rising edge, with a capture watchdog and an optional sliding-window
// averager over the last 2^AVG_LOG2 samples (compiled in when ADC_CAPTURE_AVG_EN is defined).
module adc_capture_avg #(
  parameter int DATA_W      = 8,
  parameter int AVG_LOG2    = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk_sample,
  input  logic              rstn,
  input  logic              sample_enable,
  input  logic              OE,
  input  logic [DATA_W-1:0] adc_data,
  output logic [DATA_W-1:0] raw_data,
  output logic              raw_valid,
  output logic [DATA_W-1:0] avg_out,
  output logic              avg_valid,
  output logic              timeout_err
);

  localparam logic [15:0] WD_MAX = 16'(TIMEOUT_CYC - 1);

  if (AVG_LOG2 < 1 || AVG_LOG2 > 4) begin : g_bad_avg
    $error("AVG_LOG2 must be 1..4");
  end
  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_to
    $error("TIMEOUT_CYC must be 2..65535");
  end

  logic        oe_d;
  logic        capture;
  logic [15:0] wd_cnt;

  // oe_d keeps tracking OE while disabled, so a rise coinciding with re-enable is seen
  assign capture = OE & ~oe_d & sample_enable;

  always_ff @(posedge clk_sample or negedge rstn) begin
    if (!rstn) begin
      oe_d      <= 1'b0;
      raw_data  <= '0;
      raw_valid <= 1'b0;
    end else begin
      oe_d      <= OE;
      raw_valid <= capture;
      if (capture) raw_data <= adc_data;
    end
  end

  always_ff @(posedge clk_sample or negedge rstn) begin
    if (!rstn) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else if (!sample_enable || capture) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else if (wd_cnt == WD_MAX) begin
      timeout_err <= 1'b1;
    end else begin
      wd_cnt <= wd_cnt + 16'd1;
    end
  end

`ifdef ADC_CAPTURE_AVG_EN
  localparam int N      = 1 << AVG_LOG2;
  localparam int SUM_W  = DATA_W + AVG_LOG2;
  localparam int FILL_W = AVG_LOG2 + 1;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);

  logic [N-1:0][DATA_W-1:0] sample_buf;
  logic [SUM_W-1:0]         sum, sum_next;
  logic [FILL_W-1:0]        fill, fill_next;
  logic [DATA_W-1:0]        oldest;

  // the sample leaving the window only counts once the window is full
  always_comb begin
    oldest    = (fill == FILL_FULL) ? sample_buf[N-1] : '0;
    sum_next  = sum + SUM_W'(adc_data) - SUM_W'(oldest);
    fill_next = (fill == FILL_FULL) ? fill : fill + 1'b1;
  end

  always_ff @(posedge clk_sample or negedge rstn) begin
    if (!rstn) begin
      sample_buf <= '0;
      sum        <= '0;
      fill       <= '0;
      avg_out    <= '0;
      avg_valid  <= 1'b0;
    end else if (!sample_enable) begin
      sample_buf <= '0;
      sum        <= '0;
      fill       <= '0;
      avg_valid  <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (capture) begin
        sample_buf <= {sample_buf[N-2:0], adc_data};
        sum        <= sum_next;
        fill       <= fill_next;
        if (fill_next == FILL_FULL) begin
          avg_out   <= sum_next[SUM_W-1:AVG_LOG2];
          avg_valid <= 1'b1;
        end
      end
    end
  end
`else
  assign avg_out   = '0;
  assign avg_valid = 1'b0;
`endif

endmodule

// File: tb/tb_adc_capture_avg.sv
// Randomized and directed checks of adc_capture_avg against a queue-based reference model.
module tb_adc_capture_avg;
  localparam int N  = 4;
  localparam int TO = 64;
`ifdef ADC_CAPTURE_AVG_EN
  localparam bit AVG_ON = 1'b1;
`else
  localparam bit AVG_ON = 1'b0;
`endif

  logic       clk_sample = 1'b0;
  logic       rstn, sample_enable, OE;
  logic [7:0] adc_data;
  logic [7:0] raw_data, avg_out;
  logic       raw_valid, avg_valid, timeout_err;

  always #5 clk_sample = ~clk_sample;

  adc_capture_avg #(.DATA_W(8), .AVG_LOG2(2), .TIMEOUT_CYC(TO)) dut (
    .clk_sample(clk_sample), .rstn(rstn), .sample_enable(sample_enable), .OE(OE),
    .adc_data(adc_data), .raw_data(raw_data), .raw_valid(raw_valid),
    .avg_out(avg_out), .avg_valid(avg_valid), .timeout_err(timeout_err)
  );

  int total = 0;
  int bad   = 0;

  // reference model: history of captured samples since the last clear
  int         q[$];
  logic       m_prev_oe, m_rv, m_av, m_err;
  logic [7:0] m_raw, m_avg;
  int         idle;

  wire [18:0] obs = {raw_data, raw_valid, avg_out, avg_valid, timeout_err};

  function automatic logic [18:0] expv();
    return {m_raw, m_rv, (AVG_ON ? m_avg : 8'h00), (AVG_ON ? m_av : 1'b0), m_err};
  endfunction

  task automatic model_reset();
    q.delete();
    m_prev_oe = 1'b0; m_raw = '0; m_avg = '0;
    m_rv = 1'b0; m_av = 1'b0; m_err = 1'b0; idle = 0;
  endtask

  task automatic model_step(input logic oe, input logic en, input logic [7:0] d);
    logic cap;
    int   s;
    cap = oe && !m_prev_oe && en;
    m_prev_oe = oe;
    m_rv = cap;
    m_av = 1'b0;
    if (!en) begin
      q.delete(); idle = 0; m_err = 1'b0;
    end else if (cap) begin
      m_raw = d;
      q.push_back(int'(d));
      if (q.size() > N) void'(q.pop_front());
      if (q.size() == N) begin
        s = 0;
        foreach (q[i]) s += q[i];
        m_avg = 8'(s / N);
        m_av  = 1'b1;
      end
      idle = 0; m_err = 1'b0;
    end else begin
      if (idle < 1000000) idle++;
      if (idle >= TO) m_err = 1'b1;
    end
  endtask

  task automatic cycle(input logic oe, input logic en, input logic [7:0] d);
    OE = oe; sample_enable = en; adc_data = d;
    @(posedge clk_sample);
    model_step(oe, en, d);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b1; OE = 1'b0; sample_enable = 1'b0; adc_data = '0;
    #2 rstn = 1'b0;
    model_reset();
    #1;
    if (obs !== 19'h0) begin bad++; $display("FAIL reset got=%h want=%h", obs, 19'h0); end
    total++;
    @(posedge clk_sample); #1;
    rstn = 1'b1;
  endtask

  task automatic test_fill();
    int nrv = 0, nav = 0;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) cycle(1'b1, 1'b1, 8'(16 * (i / 2 + 1)));
      else            cycle(1'b0, 1'b1, 8'($urandom));
      if (obs !== expv()) begin bad++; $display("FAIL fill c%0d got=%h want=%h", i, obs, expv()); end
      total++;
      nrv += int'(raw_valid); nav += int'(avg_valid);
    end
    if (nrv !== 4) begin bad++; $display("FAIL fill_rv_count got=%0d want=4", nrv); end
    total++;
    if (nav !== (AVG_ON ? 1 : 0)) begin bad++; $display("FAIL fill_av_count got=%0d want=%0d", nav, AVG_ON ? 1 : 0); end
    total++;
    if (avg_out !== (AVG_ON ? 8'h28 : 8'h00)) begin bad++; $display("FAIL fill_avg got=%h want=%h", avg_out, AVG_ON ? 8'h28 : 8'h00); end
    total++;
  endtask

  task automatic test_slide_hold();
    int nrv = 0;
    int want;
    want = (32'h20 + 32'h30 + 32'h40 + 32'hFF) >> 2;
    cycle(1'b1, 1'b1, 8'hFF);
    if (obs !== expv()) begin bad++; $display("FAIL slide got=%h want=%h", obs, expv()); end
    total++;
    if (avg_out !== (AVG_ON ? 8'(want) : 8'h00) || avg_valid !== AVG_ON) begin
      bad++; $display("FAIL slide_avg got=%h/%b want=%h/%b", avg_out, avg_valid, AVG_ON ? 8'(want) : 8'h00, AVG_ON);
    end
    total++;
    for (int i = 0; i < 6; i++) begin
      cycle((i >= 1 && i <= 3), 1'b1, 8'($urandom));
      if (obs !== expv()) begin bad++; $display("FAIL hold c%0d got=%h want=%h", i, obs, expv()); end
      total++;
      nrv += int'(raw_valid);
    end
    if (nrv !== 1) begin bad++; $display("FAIL hold_rv_count got=%0d want=1", nrv); end
    total++;
  endtask

  task automatic test_timeout();
    int rise = 0;
    cycle(1'b1, 1'b1, 8'h33);
    for (int k = 1; k <= TO + 10; k++) begin
      cycle(1'b0, 1'b1, 8'($urandom));
      if (obs !== expv()) begin bad++; $display("FAIL timeout c%0d got=%h want=%h", k, obs, expv()); end
      total++;
      if (timeout_err && rise == 0) rise = k;
    end
    if (rise !== TO) begin bad++; $display("FAIL timeout_rise got=%0d want=%0d", rise, TO); end
    total++;
    if (timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_sticky got=%b want=1", timeout_err); end
    total++;
    cycle(1'b1, 1'b1, 8'h44);
    if (timeout_err !== 1'b0 || raw_data !== 8'h44) begin
      bad++; $display("FAIL timeout_clear got=%b/%h want=0/44", timeout_err, raw_data);
    end
    total++;
    cycle(1'b0, 1'b1, 8'h00);
  endtask

  task automatic test_enable_drop();
    int nav = 0;
    cycle(1'b1, 1'b1, 8'h55); cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b1, 1'b1, 8'h66); cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 8'h77);
    if (obs !== expv() || raw_valid !== 1'b0 || timeout_err !== 1'b0 || raw_data !== 8'h66) begin
      bad++; $display("FAIL en_drop got=%h want=%h", obs, expv());
    end
    total++;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) cycle(1'b1, 1'b1, 8'h08);
      else            cycle(1'b0, 1'b1, 8'($urandom));
      if (obs !== expv()) begin bad++; $display("FAIL refill c%0d got=%h want=%h", i, obs, expv()); end
      total++;
      if (i < 6) nav += int'(avg_valid);
    end
    if (nav !== 0) begin bad++; $display("FAIL refill_early_av got=%0d want=0", nav); end
    total++;
    if (avg_out !== (AVG_ON ? 8'h08 : 8'h00)) begin bad++; $display("FAIL refill_avg got=%h want=%h", avg_out, AVG_ON ? 8'h08 : 8'h00); end
    total++;
  endtask

  task automatic test_reset_mid();
    int nav = 0;
    cycle(1'b1, 1'b1, 8'h11); cycle(1'b0, 1'b1, 8'h00); cycle(1'b1, 1'b1, 8'h22);
    #2 rstn = 1'b0;
    model_reset();
    #1;
    if (obs !== 19'h0) begin bad++; $display("FAIL reset_mid got=%h want=%h", obs, 19'h0); end
    total++;
    @(posedge clk_sample); #1;
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle(i % 2 == 0, 1'b1, 8'($urandom));
      if (obs !== expv()) begin bad++; $display("FAIL post_reset c%0d got=%h want=%h", i, obs, expv()); end
      total++;
      if (i < 6) nav += int'(avg_valid);
    end
    if (nav !== 0) begin bad++; $display("FAIL post_reset_early_av got=%0d want=0", nav); end
    total++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 2) == 0, $urandom_range(0, 19) != 0, 8'($urandom));
      if (obs !== expv()) begin bad++; $display("FAIL random c%0d got=%h want=%h", i, obs, expv()); end
      total++;
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_slide_hold();
    test_timeout();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
